// File: rtl/run_ctrl_if.sv
// Load-stream and program-memory write bus of the run-control sequencer.
// The master side is the debug host; the slave side is run_ctrl.
interface run_ctrl_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_last;
    logic              load_ready;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;

    modport master (
        output load_valid, load_data, load_last,
        input  load_ready, prog_we, prog_addr, prog_data
    );

    modport slave (
        input  load_valid, load_data, load_last,
        output load_ready, prog_we, prog_addr, prog_data
    );
endinterface

// File: rtl/run_ctrl.sv
// Run-control sequencer for the 8-bit accumulator core.
// Loads program memory and gates the core pause for run/step/stop.
module run_ctrl #(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 8,
    parameter int CNT_W      = 16,
    parameter int MAX_CYCLES = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              step,
    input  logic              load_start,
    run_ctrl_if.slave         lb,
    input  logic              bp_en,
    input  logic [ADDR_W-1:0] bp_addr,
    input  logic [ADDR_W-1:0] pc,
    input  logic              hlt_in,
    output logic              pause,
    output logic [2:0]        state,
    output logic              timeout,
    output logic [CNT_W-1:0]  cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RUN  = 3'd2,
        S_STEP = 3'd3,
        S_BRK  = 3'd4,
        S_HALT = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0]  LIMIT     = CNT_W'(MAX_CYCLES - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t state_q, state_d;
    state_t ret_q, ret_d;
    logic first_q, first_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic to_q, to_d;
    logic pause_q, ready_q, we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;

    logic [3:0] req_q;
    logic [3:0] req;
    logic start_p, stop_p, step_p, load_p;
    logic hs, bp_hit, last_byte;

    assign req     = {load_start, step, stop, start};
    assign start_p = req[0] & ~req_q[0];
    assign stop_p  = req[1] & ~req_q[1];
    assign step_p  = req[2] & ~req_q[2];
    assign load_p  = req[3] & ~req_q[3];

    assign hs        = (state_q == S_LOAD) && lb.load_valid && ready_q;
    assign bp_hit    = bp_en && (pc == bp_addr) && !first_q;
    assign last_byte = lb.load_last || (ptr_q == LAST_ADDR);

    // Next-state logic: stop wins everywhere, HALT only leaves on reset.
    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        first_d = 1'b0;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        to_d    = to_q;
        unique case (state_q)
            S_IDLE: begin
                if (load_p) begin
                    state_d = S_LOAD;
                    ptr_d   = '0;
                end else if (start_p) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    first_d = 1'b1;
                end else if (step_p) begin
                    state_d = S_STEP;
                    ret_d   = S_IDLE;
                end
            end
            S_LOAD: begin
                if (hs) ptr_d = ptr_q + 1'b1;
                if (stop_p) state_d = S_IDLE;
                else if (hs && last_byte) state_d = S_IDLE;
            end
            S_RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (stop_p) state_d = S_IDLE;
                else if (hlt_in) state_d = S_HALT;
                else if (bp_hit) state_d = S_BRK;
                else if (cnt_q >= LIMIT) begin
                    state_d = S_HALT;
                    to_d    = 1'b1;
                end
            end
            S_STEP: begin
                if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                if (stop_p) state_d = S_IDLE;
                else if (hlt_in) state_d = S_HALT;
                else state_d = ret_q;
            end
            S_BRK: begin
                if (stop_p) state_d = S_IDLE;
                else if (start_p) begin
                    state_d = S_RUN;
                    first_d = 1'b1;
                end else if (step_p) begin
                    state_d = S_STEP;
                    ret_d   = S_BRK;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sequencer state, counters and request history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ret_q   <= S_IDLE;
            first_q <= 1'b0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            to_q    <= 1'b0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            first_q <= first_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
            req_q   <= req;
        end
    end

    // Registered outputs derived from the upcoming state and load handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pause_q <= 1'b1;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            pause_q <= !((state_d == S_RUN) || (state_d == S_STEP));
            ready_q <= (state_d == S_LOAD);
            we_q    <= hs;
            if (hs) begin
                addr_q <= ptr_q;
                data_q <= lb.load_data;
            end
        end
    end

    assign pause         = pause_q;
    assign state         = state_q;
    assign timeout       = to_q;
    assign cycle_count   = cnt_q;
    assign lb.load_ready = ready_q;
    assign lb.prog_we    = we_q;
    assign lb.prog_addr  = addr_q;
    assign lb.prog_data  = data_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl: write scoreboard for loads, PC model for runs.
// Small run budget so the timeout path is reachable.
module tb_run_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic stop = 1'b0;
    logic step = 1'b0;
    logic load_start = 1'b0;
    logic bp_en = 1'b0;
    logic [3:0] bp_addr = '0;
    logic [3:0] pc = '0;
    logic hlt_in = 1'b0;
    logic pause;
    logic [2:0] state;
    logic timeout;
    logic [15:0] cycle_count;

    logic pc_clr = 1'b0;
    int exec_cnt = 0;

    int checks = 0;
    int failures = 0;
    int writes = 0;
    logic [11:0] exp_q[$];
    logic [3:0] ptr_m;

    run_ctrl_if #(.ADDR_W(4), .DATA_W(8)) lb ();

    run_ctrl #(
        .ADDR_W(4), .DATA_W(8), .CNT_W(16), .MAX_CYCLES(10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .stop(stop),
        .step(step),
        .load_start(load_start),
        .lb(lb),
        .bp_en(bp_en),
        .bp_addr(bp_addr),
        .pc(pc),
        .hlt_in(hlt_in),
        .pause(pause),
        .state(state),
        .timeout(timeout),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    // Core model: PC advances and a cycle executes whenever not paused.
    always @(posedge clk) begin
        if (pc_clr) pc <= '0;
        else if (!pause) pc <= pc + 4'd1;
        if (!pause) exec_cnt <= exec_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        logic [11:0] e;
        @(negedge clk);
        if (lb.prog_we === 1'b1) begin
            writes++;
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_we", 32'(lb.prog_we), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(lb.prog_addr), 32'(e[11:8]));
                chk("wr_data", 32'(lb.prog_data), 32'(e[7:0]));
            end
        end
    endtask

    task automatic pulse(input int k);
        tick();
        case (k)
            0: start = 1'b1;
            1: stop = 1'b1;
            2: step = 1'b1;
            default: load_start = 1'b1;
        endcase
        tick();
        start = 1'b0;
        stop = 1'b0;
        step = 1'b0;
        load_start = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic last,
                        output logic ok);
        ok = 1'b0;
        tick();
        lb.load_valid = 1'b1;
        lb.load_data = d;
        lb.load_last = last;
        chk("load_pause", 32'(pause), 32'd1);
        for (int i = 0; i < 6 && !ok; i++) begin
            if (lb.load_ready === 1'b1) begin
                exp_q.push_back({ptr_m, d});
                ptr_m = ptr_m + 4'd1;
                ok = 1'b1;
            end else begin
                tick();
            end
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input int lim,
                              input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < lim && !ok; i++) begin
            tick();
            if (state == s) ok = 1'b1;
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_state"}, 32'(state), 32'd0);
        chk({tag, "_pause"}, 32'(pause), 32'd1);
        chk({tag, "_ready"}, 32'(lb.load_ready), 32'd0);
        chk({tag, "_we"}, 32'(lb.prog_we), 32'd0);
        chk({tag, "_addr"}, 32'(lb.prog_addr), 32'd0);
        chk({tag, "_data"}, 32'(lb.prog_data), 32'd0);
        chk({tag, "_timeout"}, 32'(timeout), 32'd0);
        chk({tag, "_count"}, 32'(cycle_count), 32'd0);
    endtask

    initial begin
        logic ok;
        int w0, acc, e0, c0, pz;
        logic [3:0] pc0;
        lb.load_valid = 1'b0;
        lb.load_data = '0;
        lb.load_last = 1'b0;
        ptr_m = '0;

        tick();
        check_reset_outputs("rst");
        tick();
        rst = 1'b0;
        pc_clr = 1'b1;
        tick();
        pc_clr = 1'b0;

        // Three-byte load ended by load_last.
        w0 = writes;
        pulse(3);
        chk("load_enter", 32'(state), 32'd1);
        ptr_m = '0;
        send(8'h93, 1'b0, ok);
        send(8'h63, 1'b0, ok);
        send(8'h15, 1'b1, ok);
        tick();
        lb.load_valid = 1'b0;
        lb.load_last = 1'b0;
        tick();
        chk("load3_writes", 32'(writes - w0), 32'd3);
        chk("load3_drain", 32'(exp_q.size()), 32'd0);
        chk("load3_idle", 32'(state), 32'd0);
        chk("load3_pause", 32'(pause), 32'd1);

        // Seventeen bytes without load_last: memory end closes the load.
        w0 = writes;
        acc = 0;
        pulse(3);
        ptr_m = '0;
        for (int i = 0; i < 17; i++) begin
            send(8'h20 + 8'(i), 1'b0, ok);
            if (ok) acc++;
        end
        lb.load_valid = 1'b0;
        tick();
        tick();
        chk("load17_accepted", 32'(acc), 32'd16);
        chk("load17_writes", 32'(writes - w0), 32'd16);
        chk("load17_idle", 32'(state), 32'd0);
        chk("load17_ready", 32'(lb.load_ready), 32'd0);

        // Breakpoint at PC 5, then resume with breakpoint on current PC.
        pc_clr = 1'b1;
        tick();
        pc_clr = 1'b0;
        bp_en = 1'b1;
        bp_addr = 4'd5;
        pulse(0);
        wait_state(3'd4, 40, "brk_reach");
        chk("brk_pause", 32'(pause), 32'd1);
        chk("brk_pc_window", 32'(pc >= 4'd5 && pc <= 4'd6), 32'd1);
        chk("brk_count_vs_pc", 32'(cycle_count), 32'(pc));
        c0 = int'(cycle_count);
        bp_addr = pc;
        pulse(0);
        chk("resume_run", 32'(state), 32'd2);
        tick();
        chk("resume_no_rebrk", 32'(state), 32'd2);
        pulse(1);
        chk("resume_stop_idle", 32'(state), 32'd0);
        chk("resume_count", 32'(cycle_count), 32'(c0 + 3));

        // Three single steps from BRK.
        pc_clr = 1'b1;
        tick();
        pc_clr = 1'b0;
        bp_addr = 4'd2;
        pulse(0);
        wait_state(3'd4, 40, "brk2_reach");
        chk("brk2_count", 32'(cycle_count), 32'd3);
        c0 = int'(cycle_count);
        for (int i = 0; i < 3; i++) begin
            pz = exec_cnt;
            pc0 = pc;
            pulse(2);
            tick();
            tick();
            chk("step_state", 32'(state), 32'd4);
            chk("step_one_cycle", 32'(exec_cnt - pz), 32'd1);
            chk("step_pc", 32'(pc), 32'(pc0 + 4'd1));
        end
        chk("step_count", 32'(cycle_count), 32'(c0 + 3));
        pulse(1);
        chk("step_stop_idle", 32'(state), 32'd0);
        bp_en = 1'b0;

        // HLT and stop together: stop wins.
        pulse(0);
        tick();
        hlt_in = 1'b1;
        stop = 1'b1;
        tick();
        hlt_in = 1'b0;
        stop = 1'b0;
        chk("hltstop_state", 32'(state), 32'd0);
        chk("hltstop_timeout", 32'(timeout), 32'd0);
        chk("hltstop_pause", 32'(pause), 32'd1);

        // Run budget exhausted.
        e0 = exec_cnt;
        pulse(0);
        wait_state(3'd5, 40, "halt_reach");
        chk("halt_exec", 32'(exec_cnt - e0), 32'd10);
        chk("halt_count", 32'(cycle_count), 32'd10);
        chk("halt_timeout", 32'(timeout), 32'd1);
        chk("halt_pause", 32'(pause), 32'd1);
        e0 = exec_cnt;
        pulse(0);
        pulse(2);
        pulse(1);
        tick();
        chk("halt_hold_state", 32'(state), 32'd5);
        chk("halt_hold_count", 32'(cycle_count), 32'd10);
        chk("halt_hold_timeout", 32'(timeout), 32'd1);
        chk("halt_hold_exec", 32'(exec_cnt - e0), 32'd0);

        // Reset leaves HALT and clears the sticky timeout.
        rst = 1'b1;
        tick();
        check_reset_outputs("rst2");
        rst = 1'b0;
        tick();

        // Reset right after a load handshake.
        pulse(3);
        ptr_m = '0;
        send(8'hA5, 1'b0, ok);
        chk("midload_accept", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("midload");
        exp_q.delete();
        lb.load_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_idle", 32'(state), 32'd0);
        chk("post_rst_we", 32'(lb.prog_we), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
